// File: rtl/fifo_pkg.sv
// fifo_pkg: shared packer defaults, lane-count width, keep typedef and lane-mask helper
package fifo_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int RATIO_DEF = 4;
  localparam int LANE_CNT_W = $clog2(RATIO_DEF + 1);
  typedef logic [RATIO_DEF-1:0] keep_t;
  function automatic logic [31:0] lane_mask(input int n);
    return (n >= 32) ? '1 : (32'd1 << n) - 32'd1;
  endfunction
endpackage

// File: rtl/fifo_word_packer_pack_out_reg.sv
// pack_out_reg: single-entry valid/ready holding register for packed data, keep and last
module pack_out_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] in_data,
  input  logic [KW-1:0] in_keep,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [KW-1:0] out_keep,
  output logic          out_last
);
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops FIFO entries and packs RATIO of them into one valid/ready word with flush
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RATIO = RATIO_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [WIDTH-1:0]       fifo_rd_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_last,
  output logic                   flush_done
);
  localparam int OW = WIDTH * RATIO;
  localparam int CW = $clog2(RATIO + 1);
  logic [CW-1:0] cnt, lanes_now;
  logic [OW-1:0] acc, word_now;
  logic          in_flight, pend, pend_eff, out_free, resolve, commit;
  assign lanes_now  = cnt + CW'(in_flight);
  assign word_now   = in_flight ? acc | (OW'(fifo_rd_data) << (WIDTH * int'(cnt))) : acc;
  assign out_free   = !out_valid || out_ready;
  assign pend_eff   = pend || flush;
  assign resolve    = pend_eff && !in_flight && out_free;
  assign commit     = out_free && ((lanes_now == CW'(RATIO)) || (resolve && cnt != '0));
  assign fifo_rd_en = rst_n && !fifo_empty && !pend_eff &&
                      ((commit ? CW'(0) : lanes_now) < CW'(RATIO));
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt        <= '0;
      acc        <= '0;
      in_flight  <= 1'b0;
      pend       <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      cnt        <= commit ? '0 : lanes_now;
      acc        <= commit ? '0 : word_now;
      in_flight  <= fifo_rd_en;
      pend       <= pend_eff && !resolve;
      flush_done <= resolve;
    end
  pack_out_reg #(.DW(OW), .KW(RATIO)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (commit),
    .in_data   (word_now),
    .in_keep   (RATIO'(lane_mask(int'(lanes_now)))),
    .in_last   (pend_eff),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: directed and random checks of fifo_word_packer against a byte-stream model
module tb_fifo_word_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        flush_done;
  int          n_asserts = 0, n_fail = 0;
  int          pops = 0, run = 0, max_run = 0, fd_cnt = 0, cyc = 0;
  bit          rnd = 0, tog = 0, prev_hold = 0;
  logic        s_fd, s_valid;
  logic [63:0] prev_w;
  logic [7:0]  fq[$];
  logic [7:0]  rb[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_word_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .flush_done   (flush_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ew(input logic [31:0] d, input logic [3:0] k, input logic l);
    return {27'd0, l, k, d};
  endfunction

  task automatic tick();
    logic [63:0] w;
    bit pop;
    @(negedge clk);
    cyc++;
    w = {27'd0, out_last, out_keep, out_data};
    chk("rd_en_while_empty", 64'(fifo_rd_en & fifo_empty), 64'd0);
    if (!rst_n) chk("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
    if (prev_hold) chk("hold_stable", {w[62:0], out_valid}, {prev_w[62:0], 1'b1});
    prev_hold = out_valid && !out_ready;
    prev_w = w;
    pop = fifo_rd_en;
    if (pop) begin
      pops++;
      run++;
      max_run = run > max_run ? run : max_run;
    end else run = 0;
    fd_cnt += int'(flush_done);
    s_fd = flush_done;
    s_valid = out_valid;
    if (out_valid && out_ready) chk("word", w, exp_q.size() > 0 ? exp_q.pop_front() : '1);
    @(posedge clk);
    #1;
    if (pop && fq.size() > 0) fifo_rd_data = fq.pop_front();
    flush = 1'b0;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    fifo_empty = fq.size() == 0 || (tog && cyc % 2 == 0) || (rnd && $urandom_range(0, 2) == 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'(first + i));
    fifo_empty = 1'b0;
  endtask

  initial begin
    ticks(2);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_keep", 64'(out_keep), 0);
    chk("rst_out_last", 64'(out_last), 0);
    chk("rst_flush_done", 64'(flush_done), 0);
    rst_n = 1'b1;
    tick();

    exp_q.push_back(ew(32'h04030201, 4'hF, 1'b0));
    exp_q.push_back(ew(32'h08070605, 4'hF, 1'b0));
    pops = 0; run = 0; max_run = 0;
    push_seq(1, 8);
    ticks(16);
    chk("t1_pops", 64'(pops), 8);
    chk("t1_rd_en_run", 64'(max_run), 8);
    chk("t1_words_left", 64'(exp_q.size()), 0);

    exp_q.push_back(ew(32'h04030201, 4'hF, 1'b0));
    exp_q.push_back(ew(32'h08070605, 4'hF, 1'b0));
    exp_q.push_back(ew(32'h0C0B0A09, 4'hF, 1'b0));
    out_ready = 1'b0;
    pops = 0;
    push_seq(1, 12);
    ticks(10);
    chk("t2_stall_pops", 64'(pops), 8);
    chk("t2_stall_rd_en", 64'(fifo_rd_en), 0);
    chk("t2_stall_valid", 64'(out_valid), 1);
    chk("t2_stall_data", 64'(out_data), 64'h04030201);
    out_ready = 1'b1;
    ticks(16);
    chk("t2_words_left", 64'(exp_q.size()), 0);

    fq.push_back(8'hAA); fq.push_back(8'hBB); fq.push_back(8'hCC);
    fifo_empty = 1'b0;
    ticks(6);
    exp_q.push_back(ew(32'h00CCBBAA, 4'h7, 1'b1));
    fq.push_back(8'hDD);
    fifo_empty = 1'b0;
    flush = 1'b1;
    pops = 0; fd_cnt = 0;
    tick();
    chk("t3_pop_suppressed", 64'(pops), 0);
    ticks(6);
    chk("t3_flush_done_once", 64'(fd_cnt), 1);
    chk("t3_words_left", 64'(exp_q.size()), 0);
    chk("t3_dd_popped", 64'(pops), 1);
    exp_q.push_back(ew(32'h000000DD, 4'h1, 1'b1));
    flush = 1'b1;
    fd_cnt = 0;
    ticks(6);
    chk("t3b_flush_done_once", 64'(fd_cnt), 1);
    chk("t3b_words_left", 64'(exp_q.size()), 0);

    flush = 1'b1;
    fd_cnt = 0;
    tick();
    chk("t4_fd_flush_cycle", 64'(s_fd), 0);
    tick();
    chk("t4_fd_next_cycle", 64'(s_fd), 1);
    chk("t4_no_valid", 64'(s_valid), 0);
    tick();
    chk("t4_fd_after", 64'(s_fd), 0);
    ticks(3);
    chk("t4_fd_count", 64'(fd_cnt), 1);

    exp_q.push_back(ew(32'h13121110, 4'hF, 1'b0));
    exp_q.push_back(ew(32'h17161514, 4'hF, 1'b0));
    tog = 1;
    push_seq(8'h10, 8);
    ticks(26);
    tog = 0;
    chk("t5_words_left", 64'(exp_q.size()), 0);

    push_seq(8'h40, 3);
    ticks(3);
    rst_n = 1'b0;
    fq.delete();
    fifo_empty = 1'b1;
    tick();
    chk("t6_rst_valid", 64'(out_valid), 0);
    chk("t6_rst_data", 64'(out_data), 0);
    chk("t6_rst_keep", 64'(out_keep), 0);
    chk("t6_rst_last", 64'(out_last), 0);
    chk("t6_rst_fd", 64'(flush_done), 0);
    rst_n = 1'b1;
    exp_q.push_back(ew(32'h24232221, 4'hF, 1'b0));
    push_seq(8'h21, 4);
    ticks(10);
    chk("t6_words_left", 64'(exp_q.size()), 0);

    begin
      int n;
      n = 4 * int'($urandom_range(3, 6)) + int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) rb.push_back(8'($urandom_range(0, 255)));
      for (int w = 0; w * 4 < n; w++) begin
        logic [31:0] d;
        int k;
        d = 0;
        k = 0;
        for (int i = 0; i < 4 && w * 4 + i < n; i++) begin
          d |= 32'(rb[w * 4 + i]) << (8 * i);
          k++;
        end
        exp_q.push_back(ew(d, 4'((1 << k) - 1), k < 4));
      end
      foreach (rb[i]) fq.push_back(rb[i]);
      fifo_empty = 1'b0;
      rnd = 1;
      for (int i = 0; i < 600 && fq.size() > 0; i++) tick();
      rnd = 0;
      out_ready = 1'b1;
      chk("rand_drained", 64'(fq.size()), 0);
      ticks(12);
      flush = 1'b1;
      fd_cnt = 0;
      ticks(8);
      chk("rand_flush_done", 64'(fd_cnt), 1);
      chk("rand_words_left", 64'(exp_q.size()), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
